// File: rtl/instr_glyph_plotter.sv
// Glyph box plotter: fetches 16 bitmap rows from a synchronous glyph ROM and
// sweeps a SCALE-magnified 16x16 box into a pixel-write interface.
module instr_glyph_plotter #(
  parameter int unsigned ORIGIN_X  = 64,
  parameter int unsigned ORIGIN_Y  = 44,
  parameter int unsigned SCALE     = 2,
  parameter logic [2:0]  FG_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  instr,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned SW = 2;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            clear_q, clear_d;
  logic [2:0]      code_q, code_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;
  logic [SW-1:0]   sx_q, sx_d;
  logic [SW-1:0]   sy_q, sy_d;
  logic [15:0]     rowbuf_q, rowbuf_d;
  logic [6:0]      rom_addr_q, rom_addr_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Pixel about to be presented on the next cycle
  logic            px_en;
  logic [3:0]      px_col;
  logic [SW-1:0]   px_sx;
  logic [SW-1:0]   px_sy;
  logic [15:0]     px_bits;
  logic            row_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      clear_q    <= 1'b0;
      code_q     <= 3'd0;
      row_q      <= 4'd0;
      col_q      <= 4'd0;
      sx_q       <= '0;
      sy_q       <= '0;
      rowbuf_q   <= 16'd0;
      rom_addr_q <= 7'd0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= 3'd0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clear_q    <= clear_d;
      code_q     <= code_d;
      row_q      <= row_d;
      col_q      <= col_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      rowbuf_q   <= rowbuf_d;
      rom_addr_q <= rom_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state, sweep counters and next-cycle output values
  always_comb begin
    state_d    = state_q;
    clear_d    = clear_q;
    code_d     = code_q;
    row_d      = row_q;
    col_d      = col_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    rowbuf_d   = rowbuf_q;
    rom_addr_d = rom_addr_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    px_en      = 1'b0;
    px_col     = col_q;
    px_sx      = sx_q;
    px_sy      = sy_q;
    px_bits    = rowbuf_q;
    row_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_d = instr[3];
          code_d  = instr[2:0];
          if (instr[2:0] > 3'd5) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = S_FETCH;
            busy_d     = 1'b1;
            row_d      = 4'd0;
            rom_addr_d = {instr[2:0], 4'd0};
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        rowbuf_d = rom_data;
        col_d    = 4'd0;
        sx_d     = '0;
        sy_d     = '0;
        state_d  = S_DRAW;
        busy_d   = 1'b1;
        px_en    = 1'b1;
        px_col   = 4'd0;
        px_sx    = '0;
        px_sy    = '0;
        px_bits  = rom_data;
      end
      S_DRAW: begin
        busy_d = 1'b1;
        // Innermost sub_x, then column, then sub_y
        if (sx_q != SUB_LAST) begin
          sx_d = sx_q + SW'(1);
        end else begin
          sx_d = '0;
          if (col_q != 4'd15) begin
            col_d = col_q + 4'd1;
          end else begin
            col_d = 4'd0;
            if (sy_q != SUB_LAST) begin
              sy_d = sy_q + SW'(1);
            end else begin
              sy_d    = '0;
              row_end = 1'b1;
            end
          end
        end
        if (row_end) begin
          if (row_q == 4'd15) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = S_FETCH;
            row_d      = row_q + 4'd1;
            rom_addr_d = {code_q, row_q + 4'd1};
          end
        end else begin
          px_en  = 1'b1;
          px_col = col_d;
          px_sx  = sx_d;
          px_sy  = sy_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (px_en) begin
      plot_d   = 1'b1;
      x_d      = XW'(ORIGIN_X) + XW'(px_col) * XW'(SCALE) + XW'(px_sx);
      y_d      = YW'(ORIGIN_Y) + YW'(row_d) * YW'(SCALE) + YW'(px_sy);
      colour_d = (!clear_q && px_bits[4'd15 - px_col]) ? FG_COLOUR : BG_COLOUR;
    end
  end

  assign rom_addr = rom_addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_glyph_plotter.sv
// Scoreboard bench for instr_glyph_plotter: stimulus pushes expected pixels,
// fetch addresses and completion events; a negedge monitor pops and compares.
module tb_instr_glyph_plotter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  instr;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done, err;

  always #5 clk = ~clk;

  instr_glyph_plotter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
    .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done), .err(err)
  );

  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  typedef struct {int cyc; int err; int plots;} done_t;

  pix_t       exp_pix[$];
  done_t      exp_done[$];
  logic [6:0] exp_addr[$];
  logic [6:0] got_addr[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   plots_seen = 0;
  int   done_seen = 0;
  int   rom_mode = 0;
  logic [15:0] rom_val = 16'h0000;
  pix_t first_pix, last_pix, mon_e;
  done_t mon_d;
  logic prev_busy = 1'b0;
  logic [6:0] prev_addr = 7'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // External glyph ROM: one-cycle read latency
  function automatic logic [15:0] rom_fn(input logic [6:0] a);
    if (rom_mode == 0) return rom_val;
    return 16'h8000 >> a[3:0];
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Expected behaviour of one accepted command issued at absolute cycle ts
  task automatic push_sweep(input logic [3:0] ins, input int ts);
    logic [15:0] bits;
    if (ins[2:0] > 3'd5) begin
      exp_done.push_back('{ts + 1, 1, 0});
      return;
    end
    for (int r = 0; r < 16; r++) begin
      bits = rom_fn({ins[2:0], 4'(r)});
      exp_addr.push_back({ins[2:0], 4'(r)});
      for (int sy = 0; sy < 2; sy++)
        for (int c = 0; c < 16; c++)
          for (int sx = 0; sx < 2; sx++)
            exp_pix.push_back('{8'(64 + c * 2 + sx), 7'(44 + r * 2 + sy),
                                (!ins[3] && bits[15 - c]) ? 3'd7 : 3'd0});
    end
    exp_done.push_back('{ts + 1057, 0, 1024});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (plot) begin
        if (exp_pix.size() == 0) begin
          check("unexpected_plot", 1, 0);
        end else begin
          mon_e = exp_pix.pop_front();
          tests++;
          if (x !== mon_e.x || y !== mon_e.y || colour !== mon_e.c) begin
            fails++;
            $display("FAIL pixel: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                     x, y, colour, mon_e.x, mon_e.y, mon_e.c);
          end
        end
        if (plots_seen == 0) first_pix = '{x, y, colour};
        last_pix = '{x, y, colour};
        plots_seen++;
      end
      if (busy && (!prev_busy || rom_addr != prev_addr)) got_addr.push_back(rom_addr);
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_d = exp_done.pop_front();
          check("done_cycle", cyc, mon_d.cyc);
          check("err", int'(err), mon_d.err);
          check("plot_count", plots_seen, mon_d.plots);
          check("busy_at_done", int'(busy), 0);
          check("pix_left", exp_pix.size(), 0);
          check("fetch_count", got_addr.size(), exp_addr.size());
          for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            check("rom_addr", int'(got_addr[i]), int'(exp_addr[i]));
        end
        plots_seen = 0;
        exp_pix.delete();
        got_addr.delete();
        exp_addr.delete();
        done_seen++;
      end else if (err) begin
        check("err_without_done", 1, 0);
      end
    end
    prev_busy = busy;
    prev_addr = rom_addr;
  end

  task automatic issue(input logic [3:0] ins);
    @(negedge clk);
    instr = ins;
    start = 1'b1;
    t0 = cyc;
    #1 push_sweep(ins, t0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n0;
    n0 = done_seen;
    for (int i = 0; i < limit && done_seen == n0; i++) @(negedge clk);
    if (done_seen == n0) check("done_timeout", 0, 1);
  endtask

  task automatic pulse_at(input int k);
    while (cyc - t0 < k) @(negedge clk);
    instr = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_colour"}, int'(colour), 0);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    instr   = 4'd0;

    // Reset values and a quiet idle period
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check_idle_outputs("idle");

    // UP glyph, outer columns set
    rom_mode = 0; rom_val = 16'h8001;
    issue(4'b0000);
    wait_done(1200);
    check("first_x", int'(first_pix.x), 64);
    check("first_y", int'(first_pix.y), 44);
    check("first_c", int'(first_pix.c), 7);
    check("last_x", int'(last_pix.x), 95);
    check("last_y", int'(last_pix.y), 75);
    check("last_c", int'(last_pix.c), 7);
    repeat (5) @(negedge clk);

    // Clear mode with a full ROM row: background only, same fetch pattern
    rom_val = 16'hFFFF;
    issue(4'b1010);
    wait_done(1200);
    check("clear_first_c", int'(first_pix.c), 0);
    repeat (5) @(negedge clk);

    // Start re-pulsed mid-sweep must be ignored
    rom_val = 16'h8001;
    issue(4'b0000);
    pulse_at(10);
    pulse_at(500);
    wait_done(1200);
    repeat (30) @(negedge clk);

    // Invalid code, with start held into the done cycle, then a valid code
    rom_mode = 1;
    @(negedge clk);
    instr = 4'b0110;
    start = 1'b1;
    t0 = cyc;
    #1 push_sweep(4'b0110, t0);
    @(negedge clk);
    instr = 4'b0101;
    @(negedge clk);
    t0 = cyc;
    #1 push_sweep(4'b0101, t0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1200);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a sweep
    issue(4'b0000);
    while (cyc - t0 < 300) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_pix.delete();
    exp_done.delete();
    exp_addr.delete();
    got_addr.delete();
    plots_seen = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(4'b0011);
    wait_done(1200);
    check("post_reset_first_x", int'(first_pix.x), 64);
    check("post_reset_first_y", int'(first_pix.y), 44);
    check("post_reset_first_c", int'(first_pix.c), 7);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
